// File: rtl/maj_net_tt_sweep_pkg.sv
// Shared types for the majority-network truth-table sweeper.
// Operand-select fields are stored at a fixed maximum width; unused upper bits stay zero.
package maj_net_pkg;

    localparam int SEL_CONST0 = 0;
    localparam int SEL_W_MAX  = 8;

    function automatic int sel_width(input int num_inputs, input int num_nodes);
        return $clog2(1 + num_inputs + num_nodes);
    endfunction

    typedef struct packed {
        logic [2:0]           inv;
        logic [SEL_W_MAX-1:0] sel_c;
        logic [SEL_W_MAX-1:0] sel_b;
        logic [SEL_W_MAX-1:0] sel_a;
    } node_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/maj_net_tt_sweep_if.sv
// Config-write port plus truth-table valid/ready bundle for maj_net_tt_sweep.
// master = configuring/consuming agent, slave = the sweeper.
interface maj_net_tt_sweep_if #(
    parameter int NUM_INPUTS = 7,
    parameter int NUM_NODES  = 8
);
    import maj_net_pkg::*;

    localparam int SEL_W  = sel_width(NUM_INPUTS, NUM_NODES);
    localparam int ADDR_W = $clog2(NUM_NODES + 1);
    localparam int TT_W   = 1 << NUM_INPUTS;

    logic                 cfg_we;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [3*SEL_W+2:0]   cfg_wdata;
    logic                 start;
    logic                 busy;
    logic [TT_W-1:0]      tt;
    logic                 tt_valid;
    logic                 tt_ready;
    logic                 cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, tt_ready,
        input  busy, tt, tt_valid, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, tt_ready,
        output busy, tt, tt_valid, cfg_err
    );

endinterface

// File: rtl/maj_net_tt_sweep_node.sv
// One 3-input majority node; operands picked from the indices visible to it (optional inversion under MAJ_NET_INV_EN).
// Purely combinational; selects beyond AVAIL_W read as 0.
module maj3_node
    import maj_net_pkg::*;
#(
    parameter int AVAIL_W = 2
) (
    input  logic [AVAIL_W-1:0] avail_i,
    input  node_cfg_t          cfg_i,
    output logic               y_o
);

    logic a_raw;
    logic b_raw;
    logic c_raw;
    logic a;
    logic b;
    logic c;

    always_comb begin
        a_raw = 1'b0;
        b_raw = 1'b0;
        c_raw = 1'b0;
        for (int i = SEL_CONST0; i < AVAIL_W; i++) begin
            if (cfg_i.sel_a == SEL_W_MAX'(i)) a_raw = avail_i[i];
            if (cfg_i.sel_b == SEL_W_MAX'(i)) b_raw = avail_i[i];
            if (cfg_i.sel_c == SEL_W_MAX'(i)) c_raw = avail_i[i];
        end
    end

`ifdef MAJ_NET_INV_EN
    assign a = a_raw ^ cfg_i.inv[0];
    assign b = b_raw ^ cfg_i.inv[1];
    assign c = c_raw ^ cfg_i.inv[2];
`else
    // Monotone network: inversion bits are kept in the register but have no effect.
    logic unused_inv;
    assign unused_inv = ^cfg_i.inv;
    assign a = a_raw;
    assign b = b_raw;
    assign c = c_raw;
`endif

    assign y_o = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj_net_tt_sweep.sv
// Purpose: sweep all 2^NUM_INPUTS minterms through a programmable majority network (inversion under MAJ_NET_INV_EN).
// Latency: tt_valid rises TT_W+1 cycles after the start cycle; one minterm per cycle.
// Backpressure: result held in DONE until tt_ready; a start in DONE abandons or hands off and restarts.
module maj_net_tt_sweep
    import maj_net_pkg::*;
#(
    parameter int NUM_INPUTS = 7,
    parameter int NUM_NODES  = 8
) (
    input logic               clk,
    input logic               rst,
    maj_net_tt_sweep_if.slave bus_if
);

    localparam int SEL_W   = sel_width(NUM_INPUTS, NUM_NODES);
    localparam int ADDR_W  = $clog2(NUM_NODES + 1);
    localparam int TT_W    = 1 << NUM_INPUTS;
    localparam int TOT_OPS = 1 + NUM_INPUTS + NUM_NODES;
    localparam logic [SEL_W-1:0]    OUT_SEL_RST = SEL_W'(NUM_INPUTS + NUM_NODES);
    localparam logic [NUM_INPUTS:0] M_LAST      = (NUM_INPUTS + 1)'(TT_W - 1);

    node_cfg_t              node_cfg_q [NUM_NODES];
    node_cfg_t              node_cfg_d [NUM_NODES];
    logic [SEL_W-1:0]       out_sel_q;
    logic [SEL_W-1:0]       out_sel_d;
    logic                   cfg_err_q;
    logic                   cfg_err_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_INPUTS:0]    m_q;
    logic [NUM_INPUTS:0]    m_d;
    logic [TT_W-1:0]        tt_q;
    logic [TT_W-1:0]        tt_d;

    node_cfg_t              wr_cfg;
    logic [SEL_W-1:0]       wr_sel;
    logic [NUM_INPUTS:0]    base_ops;
    logic [TOT_OPS-1:0]     ops_all;
    logic                   f;

    always_comb begin
        wr_cfg       = '0;
        wr_cfg.inv   = bus_if.cfg_wdata[3*SEL_W +: 3];
        wr_cfg.sel_c = SEL_W_MAX'(bus_if.cfg_wdata[2*SEL_W +: SEL_W]);
        wr_cfg.sel_b = SEL_W_MAX'(bus_if.cfg_wdata[SEL_W +: SEL_W]);
        wr_cfg.sel_a = SEL_W_MAX'(bus_if.cfg_wdata[0 +: SEL_W]);
        wr_sel       = bus_if.cfg_wdata[SEL_W-1:0];
    end

    // Config writes: a select at or beyond a node's own index flags cfg_err but is still stored.
    always_comb begin
        node_cfg_d = node_cfg_q;
        out_sel_d  = out_sel_q;
        cfg_err_d  = cfg_err_q;
        if (bus_if.cfg_we && (state_q != SWEEP)) begin
            for (int k = 0; k < NUM_NODES; k++) begin
                if (bus_if.cfg_addr == ADDR_W'(k)) begin
                    node_cfg_d[k] = wr_cfg;
                    if ((int'(wr_cfg.sel_a) > NUM_INPUTS + k) ||
                        (int'(wr_cfg.sel_b) > NUM_INPUTS + k) ||
                        (int'(wr_cfg.sel_c) > NUM_INPUTS + k)) begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            if ((bus_if.cfg_addr == ADDR_W'(NUM_NODES)) && (int'(wr_sel) < TOT_OPS)) begin
                out_sel_d = wr_sel;
            end
        end
    end

    assign base_ops = {m_q[NUM_INPUTS-1:0], 1'b0};

    // Each node only sees constant, inputs and strictly earlier nodes, so the chain is acyclic.
    for (genvar k = 0; k < NUM_NODES; k++) begin : g_node
        logic [NUM_INPUTS+k:0] avail;
        logic                  y;
        if (k == 0) begin : g_base
            assign avail = base_ops;
        end else begin : g_chain
            assign avail = {g_node[k-1].y, g_node[k-1].avail};
        end
        maj3_node #(
            .AVAIL_W (NUM_INPUTS + 1 + k)
        ) u_node (
            .avail_i (avail),
            .cfg_i   (node_cfg_q[k]),
            .y_o     (y)
        );
    end

    assign ops_all = {g_node[NUM_NODES-1].y, g_node[NUM_NODES-1].avail};

    always_comb begin
        f = 1'b0;
        for (int i = 0; i < TOT_OPS; i++) begin
            if (out_sel_q == SEL_W'(i)) f = ops_all[i];
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        tt_d    = tt_q;
        unique case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    state_d = SWEEP;
                    m_d     = '0;
                end
            end
            SWEEP: begin
                tt_d[m_q[NUM_INPUTS-1:0]] = f;
                m_d = m_q + 1'b1;
                if (m_q == M_LAST) state_d = DONE;
            end
            DONE: begin
                if (bus_if.start) begin
                    state_d = SWEEP;
                    m_d     = '0;
                end else if (bus_if.tt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_NODES; k++) node_cfg_q[k] <= '0;
            out_sel_q <= OUT_SEL_RST;
            cfg_err_q <= 1'b0;
            state_q   <= IDLE;
            m_q       <= '0;
            tt_q      <= '0;
        end else begin
            node_cfg_q <= node_cfg_d;
            out_sel_q  <= out_sel_d;
            cfg_err_q  <= cfg_err_d;
            state_q    <= state_d;
            m_q        <= m_d;
            tt_q       <= tt_d;
        end
    end

    assign bus_if.busy     = (state_q == SWEEP);
    assign bus_if.tt_valid = (state_q == DONE);
    assign bus_if.tt       = tt_q;
    assign bus_if.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_maj_net_tt_sweep.sv
// Directed bench for maj_net_tt_sweep (NUM_INPUTS=7, NUM_NODES=8); expected tables queued, popped on handshake.
module tb_maj_net_tt_sweep;

    localparam int NI   = 7;
    localparam int NN   = 8;
    localparam int TT_W = 128;

    localparam logic [127:0] EXP_MAJ   = {16{8'hE8}};
    localparam logic [127:0] EXP_CHAIN = {16'hFFFF, 112'h0};
    localparam logic [127:0] EXP_FWD   = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 64'h0};
`ifdef MAJ_NET_INV_EN
    localparam logic [127:0] EXP_T3    = {32{4'hE}};
`else
    localparam logic [127:0] EXP_T3    = {32{4'h8}};
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [127:0] exp_q[$];

    maj_net_tt_sweep_if #(.NUM_INPUTS(NI), .NUM_NODES(NN)) dut_if ();

    maj_net_tt_sweep #(
        .NUM_INPUTS (NI),
        .NUM_NODES  (NN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] mk(input logic [2:0] inv, input int sc, input int sb, input int sa);
        return {inv, 4'(sc), 4'(sb), 4'(sa)};
    endfunction

    task automatic cfg(input int addr, input logic [14:0] data);
        dut_if.cfg_we    = 1'b1;
        dut_if.cfg_addr  = 4'(addr);
        dut_if.cfg_wdata = data;
        tick();
        dut_if.cfg_we    = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!dut_if.tt_valid && cycles < budget) begin
            if (dut_if.busy) busy_cycles++;
            tick();
            cycles++;
        end
        if (!dut_if.tt_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: tt_valid still low after %0d cycles", budget);
        end
    endtask

    task automatic do_sweep(input string name, input logic [127:0] exp);
        int c;
        int b;
        exp_q.push_back(exp);
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        wait_valid(300, c, b);
        check({name, "_latency"}, c, TT_W);
        check({name, "_busy_cycles"}, b, TT_W);
        check({name, "_busy_at_valid"}, dut_if.busy, 1'b0);
        tick();
        check({name, "_idle_after_ready"}, dut_if.tt_valid, 1'b0);
    endtask

    // Scoreboard monitor: every accepted result must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dut_if.tt_valid === 1'b1 && dut_if.tt_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: tt %h accepted with nothing queued", dut_if.tt);
                end else begin
                    check("sb_tt", dut_if.tt, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int b;
        int stable;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        dut_if.cfg_we    = 1'b0;
        dut_if.cfg_addr  = '0;
        dut_if.cfg_wdata = '0;
        dut_if.start     = 1'b0;
        dut_if.tt_ready  = 1'b1;
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", dut_if.busy, 1'b0);
        check("rst_valid", dut_if.tt_valid, 1'b0);
        check("rst_tt", dut_if.tt, 128'h0);
        check("rst_cfg_err", dut_if.cfg_err, 1'b0);

        do_sweep("default", 128'h0);
        check("default_cfg_err", dut_if.cfg_err, 1'b0);

        cfg(0, mk(3'b000, 3, 2, 1));
        cfg(8, mk(3'b000, 0, 0, 8));
        do_sweep("maj3", EXP_MAJ);

        cfg(0, mk(3'b001, 2, 1, 0));
        do_sweep("and_or", EXP_T3);

        cfg(1, mk(3'b000, 0, 6, 7));
        cfg(2, mk(3'b000, 0, 5, 9));
        cfg(8, mk(3'b000, 0, 0, 10));
        do_sweep("chain", EXP_CHAIN);
        check("chain_cfg_err", dut_if.cfg_err, 1'b0);

        cfg(2, mk(3'b000, 7, 5, 13));
        check("fwd_cfg_err", dut_if.cfg_err, 1'b1);
        do_sweep("fwd_reads0", EXP_FWD);

        // Writes during SWEEP must be dropped.
        cfg(2, mk(3'b000, 0, 5, 9));
        exp_q.push_back(EXP_CHAIN);
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        repeat (5) tick();
        cfg(2, mk(3'b000, 0, 0, 0));
        cfg(8, mk(3'b000, 0, 0, 8));
        wait_valid(300, c, b);
        tick();
        check("sticky_cfg_err", dut_if.cfg_err, 1'b1);

        // DONE held without ready, then start+ready together.
        dut_if.tt_ready = 1'b0;
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        wait_valid(300, c, b);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (dut_if.tt_valid === 1'b1 && dut_if.tt === EXP_CHAIN) stable++;
            tick();
        end
        check("done_hold_cycles", stable, 20);
        exp_q.push_back(EXP_CHAIN);
        dut_if.start    = 1'b1;
        dut_if.tt_ready = 1'b1;
        tick();
        dut_if.start = 1'b0;
        check("handoff_valid", dut_if.tt_valid, 1'b0);
        check("handoff_busy", dut_if.busy, 1'b1);
        exp_q.push_back(EXP_CHAIN);
        wait_valid(300, c, b);
        tick();

        // start in DONE without ready abandons the result.
        dut_if.tt_ready = 1'b0;
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        wait_valid(300, c, b);
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        check("abandon_valid", dut_if.tt_valid, 1'b0);
        check("abandon_busy", dut_if.busy, 1'b1);
        exp_q.push_back(EXP_CHAIN);
        dut_if.tt_ready = 1'b1;
        wait_valid(300, c, b);
        tick();

        // Async reset at minterm 37.
        cfg(0, mk(3'b000, 3, 2, 1));
        cfg(8, mk(3'b000, 0, 0, 8));
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        repeat (37) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", dut_if.busy, 1'b0);
        check("midrst_valid", dut_if.tt_valid, 1'b0);
        check("midrst_tt", dut_if.tt, 128'h0);
        check("midrst_cfg_err", dut_if.cfg_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        do_sweep("post_rst_out", 128'h0);
        cfg(8, mk(3'b000, 0, 0, 8));
        do_sweep("post_rst_node0", 128'h0);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
